cam_capture: RTL and testbench

Camera capture stage feeding the RGB frame buffer RAM. Samples an OV7670-style 8-bit parallel camera bus (pclk/vsync/href/data) in the system clock domain and assembles RGB565 byte pairs into 24-bit RGB888 pixels. Issues one write strobe per pixel with a raster address. Captures exactly one frame per `arm` request and flags completion and malformed lines.

---
 rtl/cam_pkg.sv | 35 +++
 rtl/cam_sync.sv | 64 ++++++
 rtl/cam_capture.sv | 184 ++++++++++++++++++
 tb/tb_cam_capture.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// ============================================================================
//  Module      : cam_pkg
//  Description : Shared types, default geometry and pixel expansion for the
//                camera capture stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cam_pkg;

    localparam int c_DEFAULT_WIDTH  = 320;
    localparam int c_DEFAULT_HEIGHT = 320;
    localparam int c_DEFAULT_ADDR_W = 17;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2,
        DONE    = 2'd3
    } cam_state_e;

    // Returns {B8, G8, R8}; low bits are refilled from each channel's MSBs.
    function automatic logic [23:0] rgb565_to_888(input logic [7:0] hi, input logic [7:0] lo);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5 = hi[7:3];
        g6 = {hi[2:0], lo[7:5]};
        b5 = lo[4:0];
        return {b5, b5[4:2], g6, g6[5:4], r5, r5[4:2]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cam_sync.sv
// ============================================================================
//  Module      : cam_sync
//  Description : Two-flop synchronizer for the camera bus plus a third stage
//                for pclk-rise, href-fall and vsync rise/fall edge pulses.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cam_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       cam_pclk,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_data,
    output logic       href,
    output logic [7:0] data,
    output logic       pclk_rise,
    output logic       href_fall,
    output logic       vs_rise,
    output logic       vs_fall
);

    // Control bits packed as {vsync, href, pclk}
    logic [2:0] ctl1_q, ctl1_d;
    logic [2:0] ctl2_q, ctl2_d;
    logic [2:0] ctl3_q, ctl3_d;
    logic [7:0] dat1_q, dat1_d;
    logic [7:0] dat2_q, dat2_d;

    always_comb begin
        ctl1_d = {cam_vsync, cam_href, cam_pclk};
        ctl2_d = ctl1_q;
        ctl3_d = ctl2_q;
        dat1_d = cam_data;
        dat2_d = dat1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctl1_q <= 3'd0;
            ctl2_q <= 3'd0;
            ctl3_q <= 3'd0;
            dat1_q <= 8'd0;
            dat2_q <= 8'd0;
        end else begin
            ctl1_q <= ctl1_d;
            ctl2_q <= ctl2_d;
            ctl3_q <= ctl3_d;
            dat1_q <= dat1_d;
            dat2_q <= dat2_d;
        end
    end

    assign href      = ctl2_q[1];
    assign data      = dat2_q;
    assign pclk_rise =  ctl2_q[0] & ~ctl3_q[0];
    assign href_fall = ~ctl2_q[1] &  ctl3_q[1];
    assign vs_rise   =  ctl2_q[2] & ~ctl3_q[2];
    assign vs_fall   = ~ctl2_q[2] &  ctl3_q[2];

endmodule

`default_nettype wire

// File: rtl/cam_capture.sv
// ============================================================================
//  Module      : cam_capture
//  Description : Single-frame RGB565 camera capture into an RGB888 frame
//                buffer. Optional colour-bar source: CAM_CAPTURE_TESTPAT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cam_capture
    import cam_pkg::*;
#(
    parameter int WIDTH  = c_DEFAULT_WIDTH,
    parameter int HEIGHT = c_DEFAULT_HEIGHT,
    parameter int ADDR_W = c_DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
`ifdef CAM_CAPTURE_TESTPAT_EN
    input  logic              testpat,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [23:0]       mem_data,
    output logic              mem_rw,
    output logic              mem_en,
    output logic              busy,
    output logic              frame_done,
    output logic              line_err
);

    localparam int COL_W = $clog2(WIDTH + 1);
    localparam int ROW_W = $clog2(HEIGHT + 1);

    logic       sync_href;
    logic [7:0] sync_data;
    logic       pclk_rise, href_fall, vs_rise, vs_fall;

    cam_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .cam_pclk  (cam_pclk),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .href      (sync_href),
        .data      (sync_data),
        .pclk_rise (pclk_rise),
        .href_fall (href_fall),
        .vs_rise   (vs_rise),
        .vs_fall   (vs_fall)
    );

    cam_state_e        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [23:0]       mem_data_q, mem_data_d;
    logic              mem_en_q, mem_en_d;
    logic              line_err_q, line_err_d;
    logic [23:0]       pixel;

`ifdef CAM_CAPTURE_TESTPAT_EN
    logic [15:0] col_ext;
    logic [2:0]  bar;
    assign col_ext = 16'(col_q);
    assign bar     = 3'(col_ext >> 6);
    assign pixel   = testpat ? {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}}
                             : rgb565_to_888(hi_q, sync_data);
`else
    assign pixel   = rgb565_to_888(hi_q, sync_data);
`endif

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        line_base_d = line_base_q;
        phase_d     = phase_q;
        hi_d        = hi_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_en_d    = 1'b0;
        line_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (vs_fall) begin
                    state_d     = ACTIVE;
                    col_d       = '0;
                    row_d       = '0;
                    line_base_d = '0;
                    phase_d     = 1'b0;
                end
            end
            ACTIVE: begin
                // A byte coinciding with the end of frame is discarded.
                if (vs_rise) begin
                    state_d = DONE;
                end else begin
                    if (pclk_rise && sync_href) begin
                        if (!phase_q) begin
                            hi_d    = sync_data;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (col_q < COL_W'(WIDTH)) begin
                                col_d = col_q + COL_W'(1);
                                if (row_q < ROW_W'(HEIGHT)) begin
                                    mem_en_d   = 1'b1;
                                    mem_addr_d = line_base_q + ADDR_W'(col_q);
                                    mem_data_d = pixel;
                                end
                            end
                        end
                    end
                    if (href_fall) begin
                        if (col_q != '0) begin
                            col_d = '0;
                            if (row_q < ROW_W'(HEIGHT)) begin
                                row_d       = row_q + ROW_W'(1);
                                line_base_d = line_base_q + ADDR_W'(WIDTH);
                            end
                        end
                        if (phase_q) begin
                            line_err_d = 1'b1;
                            phase_d    = 1'b0;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            line_base_q <= '0;
            phase_q     <= 1'b0;
            hi_q        <= 8'd0;
            mem_addr_q  <= '0;
            mem_data_q  <= 24'd0;
            mem_en_q    <= 1'b0;
            line_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            line_base_q <= line_base_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_en_q    <= mem_en_d;
            line_err_q  <= line_err_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_en     = mem_en_q;
    assign mem_rw     = mem_en_q;
    assign line_err   = line_err_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_cam_capture.sv
// ============================================================================
//  Module      : tb_cam_capture
//  Description : Randomised self-checking bench for cam_capture against a
//                frame-level reference model. Honours CAM_CAPTURE_TESTPAT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cam_capture;

    localparam int WIDTH  = 320;
    localparam int HEIGHT = 320;

    logic        clk = 1'b0;
    logic        rst, arm, cam_pclk, cam_vsync, cam_href;
    logic [7:0]  cam_data;
    logic [16:0] mem_addr;
    logic [23:0] mem_data;
    logic        mem_rw, mem_en, busy, frame_done, line_err;
`ifdef CAM_CAPTURE_TESTPAT_EN
    logic        testpat = 1'b0;
`endif

    always #5 clk = ~clk;

    cam_capture dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
`ifdef CAM_CAPTURE_TESTPAT_EN
        .testpat    (testpat),
`endif
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_rw     (mem_rw),
        .mem_en     (mem_en),
        .busy       (busy),
        .frame_done (frame_done),
        .line_err   (line_err)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          strobe_cnt = 0;
    bit          prev_en = 1'b0;
    bit          tp_mode = 1'b0;
    int unsigned exp_addr[$];
    logic [23:0] exp_data[$];
    logic [7:0]  fb[$];
    int          ll[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference pixel: plain arithmetic on the 5/6/5 fields, or colour bars.
    function automatic logic [23:0] ref_pixel(input int hi, input int lo, input int col);
        int r5, g6, b5, r, g, b, bar;
        if (tp_mode) begin
            bar = col / 64;
            r = (bar % 2) ? 255 : 0;
            g = ((bar / 2) % 2) ? 255 : 0;
            b = ((bar / 4) % 2) ? 255 : 0;
        end else begin
            r5 = hi / 8;
            g6 = (hi % 8) * 8 + lo / 32;
            b5 = lo % 32;
            r  = r5 * 8 + r5 / 4;
            g  = g6 * 4 + g6 / 16;
            b  = b5 * 8 + b5 / 4;
        end
        return 24'(b * 65536 + g * 256 + r);
    endfunction

    task automatic model_frame(output int n_err);
        int row = 0;
        int idx = 0;
        int px;
        n_err = 0;
        foreach (ll[i]) begin
            px = ll[i] / 2;
            for (int p = 0; p < px; p++) begin
                if (p < WIDTH && row < HEIGHT) begin
                    exp_addr.push_back(row * WIDTH + p);
                    exp_data.push_back(ref_pixel(fb[idx + 2*p], fb[idx + 2*p + 1], p));
                end
            end
            if (px > 0) row++;
            if (ll[i] % 2 == 1) n_err++;
            idx += ll[i];
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_data = b;
        cam_pclk = 1'b0;
        tick(4);
        cam_pclk = 1'b1;
        tick(4);
    endtask

    task automatic send_line(input int idx, input int len);
        cam_href = 1'b1;
        if (len == 0) begin
            tick(8);
        end else begin
            for (int k = 0; k < len; k++) send_byte(fb[idx + k]);
            cam_pclk = 1'b0;
            tick(4);
        end
        cam_href = 1'b0;
        tick(8);
    endtask

    task automatic add_line_rand(input int len);
        ll.push_back(len);
        for (int k = 0; k < len; k++) fb.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic run_frame(input bit do_arm, input bit extra_arm);
        int exp_err = 0;
        int n_exp   = 0;
        int done0   = done_cnt;
        int err0    = err_cnt;
        int s0      = strobe_cnt;
        int idx     = 0;
        if (do_arm) begin
            model_frame(exp_err);
            n_exp = exp_addr.size();
            arm = 1'b1;
            tick(1);
            arm = 1'b0;
            check_eq("busy_after_arm", busy, 1'b1);
        end
        tick(4);
        cam_vsync = 1'b0;
        tick(8);
        if (extra_arm) begin
            arm = 1'b1;
            tick(1);
            arm = 1'b0;
        end
        foreach (ll[i]) begin
            send_line(idx, ll[i]);
            idx += ll[i];
        end
        cam_vsync = 1'b1;
        for (int i = 0; i < 40 && done_cnt == done0; i++) tick(1);
        tick(4);
        check_eq("frame_done_cnt", done_cnt - done0, do_arm ? 1 : 0);
        check_eq("line_err_cnt", err_cnt - err0, exp_err);
        check_eq("strobe_cnt", strobe_cnt - s0, n_exp);
        check_eq("missing_strobes", exp_addr.size(), 0);
        check_eq("busy_idle", busy, 1'b0);
        exp_addr.delete();
        exp_data.delete();
        fb.delete();
        ll.delete();
    endtask

    always @(negedge clk) begin
        check_eq("rw_eq_en", mem_rw, mem_en);
        if (mem_en) begin
            strobe_cnt++;
            check_eq("en_single_cycle", prev_en, 1'b0);
            check_eq("strobe_expected", (exp_addr.size() != 0), 1'b1);
            if (exp_addr.size() != 0) begin
                check_eq("mem_addr", mem_addr, exp_addr.pop_front());
                check_eq("mem_data", mem_data, exp_data.pop_front());
            end
        end
        prev_en = mem_en;
        if (frame_done) done_cnt++;
        if (line_err) err_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0;
        rst = 1'b1; arm = 1'b0; cam_pclk = 1'b0; cam_vsync = 1'b1;
        cam_href = 1'b0; cam_data = 8'd0;
        tick(5);
        rst = 1'b0;
        tick(1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_mem_en", mem_en, 1'b0);
        check_eq("rst_frame_done", frame_done, 1'b0);
        check_eq("rst_line_err", line_err, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 17'd0);
        check_eq("rst_mem_data", mem_data, 24'd0);

        // Two lines of four pure-red pixels
        for (int l = 0; l < 2; l++) begin
            ll.push_back(8);
            for (int k = 0; k < 4; k++) begin
                fb.push_back(8'hF8);
                fb.push_back(8'h00);
            end
        end
        run_frame(1'b1, 1'b0);

        // Over-long line, green/blue pair, odd/empty lines; extra arm ignored
        add_line_rand(660);
        ll.push_back(4);
        fb.push_back(8'h07); fb.push_back(8'hE0);
        fb.push_back(8'h00); fb.push_back(8'h1F);
        add_line_rand(7);
        add_line_rand(0);
        add_line_rand(1);
        add_line_rand(6);
        run_frame(1'b1, 1'b1);

        // Camera traffic with no arm must produce nothing
        add_line_rand(8);
        add_line_rand(5);
        run_frame(1'b0, 1'b0);

        for (int f = 0; f < 4; f++) begin
            int nl = $urandom_range(1, 4);
            for (int l = 0; l < nl; l++) add_line_rand($urandom_range(0, 12));
            run_frame(1'b1, 1'b0);
        end

        // Reset in the middle of a line, with a write about to be strobed
        s0 = strobe_cnt;
        d0 = done_cnt;
        exp_addr.push_back(0);
        exp_data.push_back(ref_pixel(8'h12, 8'h34, 0));
        arm = 1'b1; tick(1); arm = 1'b0;
        tick(4);
        cam_vsync = 1'b0;
        tick(8);
        cam_href = 1'b1;
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        cam_data = 8'h78;
        cam_pclk = 1'b0;
        tick(4);
        cam_pclk = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_eq("rst_mid_busy", busy, 1'b0);
        check_eq("rst_mid_en", mem_en, 1'b0);
        tick(2);
        send_byte(8'h9A);
        send_byte(8'hBC);
        cam_pclk = 1'b0;
        tick(4);
        cam_href = 1'b0;
        tick(8);
        cam_vsync = 1'b1;
        tick(40);
        check_eq("rst_mid_strobes", strobe_cnt - s0, 1);
        check_eq("rst_mid_done", done_cnt - d0, 0);
        check_eq("rst_mid_busy_end", busy, 1'b0);
        exp_addr.delete();
        exp_data.delete();

`ifdef CAM_CAPTURE_TESTPAT_EN
        testpat = 1'b1;
        tp_mode = 1'b1;
        add_line_rand(400);
        run_frame(1'b1, 1'b0);
        testpat = 1'b0;
        tp_mode = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
